// File: rtl/usr_pkg.sv
// Shared types for the parametrised universal shift register.
package usr_pkg;

  localparam int USR_MODE_W = 3;

  typedef enum logic [USR_MODE_W-1:0] {
    HOLD = 3'd0,
    SHR  = 3'd1,
    SHL  = 3'd2,
    LOAD = 3'd3,
    ROR  = 3'd4,
    ROL  = 3'd5,
    ASR  = 3'd6,
    LSL  = 3'd7
  } usr_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } usr_state_e;

endpackage

// File: rtl/usr_shift_unit.sv
// Combinational next-value function of the universal shift register.
module usr_shift_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  usr_mode_e                  i_mode,
  input  logic [$clog2(WIDTH)-1:0]   i_shamt,
  input  logic [WIDTH-1:0]           i_cur,
  input  logic [WIDTH-1:0]           i_pin,
  input  logic                       i_slin,
  input  logic                       i_srin,
  output logic [WIDTH-1:0]           o_nxt
);

  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_asr;
  logic [WIDTH-1:0] w_lsl;

  // A shift by WIDTH yields zero, so shamt=0 rotates cleanly to the input.
  assign w_ror = (i_cur >> i_shamt) | (i_cur << (WIDTH - int'(i_shamt)));
  assign w_rol = (i_cur << i_shamt) | (i_cur >> (WIDTH - int'(i_shamt)));
  assign w_asr = $signed(i_cur) >>> i_shamt;
  assign w_lsl = i_cur << i_shamt;

  // Next-value mux over the eight modes.
  always_comb begin
    o_nxt = i_cur;
    case (i_mode)
      HOLD:    o_nxt = i_cur;
      SHR:     o_nxt = {i_slin, i_cur[WIDTH-1:1]};
      SHL:     o_nxt = {i_cur[WIDTH-2:0], i_srin};
      LOAD:    o_nxt = i_pin;
      ROR:     o_nxt = w_ror;
      ROL:     o_nxt = w_rol;
      ASR:     o_nxt = w_asr;
      LSL:     o_nxt = w_lsl;
      default: o_nxt = i_cur;
    endcase
  end

endmodule

// File: rtl/param_universal_shift_reg.sv
// Parametrised universal shift register with a repeat-N burst engine.
module param_universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [2:0]         mode_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               slin_i,
  input  logic               srin_i,
  input  logic [WIDTH-1:0]   pin_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic               abort_i,
  output logic [WIDTH-1:0]   pout_o,
  output logic               sout_r_o,
  output logic               sout_l_o,
  output logic               busy_o,
  output logic               done_o
);

  if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("param_universal_shift_reg: WIDTH must be a power of two >= 4");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  usr_state_e         r_state;
  usr_state_e         w_state_nxt;
  usr_mode_e          r_mode;
  logic [SHAMT_W-1:0] r_shamt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_pout;
  logic               r_done;

  usr_mode_e          w_op_mode;
  logic [SHAMT_W-1:0] w_op_shamt;
  logic               w_apply;
  logic               w_accept;
  logic               w_done_nxt;
  logic [WIDTH-1:0]   w_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start outranks en, abort outranks the final count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start_i && (count_i != CNT_ZERO)) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (abort_i || (r_cnt == CNT_ONE)) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output/datapath control decoded from the current state.
  always_comb begin
    w_op_mode  = usr_mode_e'(mode_i);
    w_op_shamt = shamt_i;
    w_apply    = 1'b0;
    w_accept   = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_accept   = (count_i != CNT_ZERO);
          w_done_nxt = (count_i == CNT_ZERO);
        end else begin
          w_apply = en_i;
        end
      end
      RUN: begin
        w_op_mode  = r_mode;
        w_op_shamt = r_shamt;
        if (abort_i) begin
          w_apply = 1'b0;
        end else begin
          w_apply    = 1'b1;
          w_done_nxt = (r_cnt == CNT_ONE);
        end
      end
      default: begin
        w_apply = 1'b0;
      end
    endcase
  end

  usr_shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift_unit (
    .i_mode  (w_op_mode),
    .i_shamt (w_op_shamt),
    .i_cur   (r_pout),
    .i_pin   (pin_i),
    .i_slin  (slin_i),
    .i_srin  (srin_i),
    .o_nxt   (w_nxt)
  );

  // Data register, burst latches, repeat counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pout  <= '0;
      r_mode  <= HOLD;
      r_shamt <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_apply) begin
        r_pout <= w_nxt;
      end
      if (w_accept) begin
        r_mode  <= usr_mode_e'(mode_i);
        r_shamt <= shamt_i;
        r_cnt   <= count_i;
      end else if (r_state == RUN) begin
        r_cnt <= abort_i ? CNT_ZERO : (r_cnt - CNT_ONE);
      end
    end
  end

  assign pout_o   = r_pout;
  assign sout_r_o = r_pout[0];
  assign sout_l_o = r_pout[WIDTH-1];
  assign busy_o   = (r_state == RUN);
  assign done_o   = r_done;

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Directed self-checking bench for param_universal_shift_reg at WIDTH=8.
module tb_param_universal_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_i;
  logic [2:0] mode_i;
  logic [2:0] shamt_i;
  logic       slin_i;
  logic       srin_i;
  logic [7:0] pin_i;
  logic       start_i;
  logic [7:0] count_i;
  logic       abort_i;
  logic [7:0] pout_o;
  logic       sout_r_o;
  logic       sout_l_o;
  logic       busy_o;
  logic       done_o;

  int n_checks = 0;
  int n_errs   = 0;

  param_universal_shift_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .mode_i   (mode_i),
    .shamt_i  (shamt_i),
    .slin_i   (slin_i),
    .srin_i   (srin_i),
    .pin_i    (pin_i),
    .start_i  (start_i),
    .count_i  (count_i),
    .abort_i  (abort_i),
    .pout_o   (pout_o),
    .sout_r_o (sout_r_o),
    .sout_l_o (sout_l_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input logic [2:0] m, input logic [2:0] s, input logic [7:0] p);
    mode_i = m; shamt_i = s; pin_i = p; en_i = 1'b1;
    tick();
    en_i = 1'b0;
  endtask

  // Rotate/shift-by-amount vectors applied from 8'h81.
  logic [2:0] v_mode [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd4};
  logic [2:0] v_sh   [5] = '{3'd3, 3'd1, 3'd2, 3'd7, 3'd0};
  logic [7:0] v_exp  [5] = '{8'h30, 8'h03, 8'hE0, 8'h80, 8'h81};

  initial begin
    rst_n = 1'b0; en_i = 1'b0; mode_i = 3'd0; shamt_i = 3'd0; slin_i = 1'b0;
    srin_i = 1'b0; pin_i = 8'h00; start_i = 1'b0; count_i = 8'd0; abort_i = 1'b0;
    #12;
    chk("rst_pout", pout_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    #20 rst_n = 1'b1;
    tick();

    // Load, then shift right with slin=1.
    single_op(3'd3, 3'd0, 8'hA5);
    chk("load_a5", pout_o, 8'hA5);
    slin_i = 1'b1;
    single_op(3'd1, 3'd0, 8'h00);
    slin_i = 1'b0;
    chk("shr_d2", pout_o, 8'hD2);
    chk("shr_sout_r", sout_r_o, 1'b0);
    chk("shr_sout_l", sout_l_o, 1'b1);

    // Barrel ops from 8'h81, including shamt=0.
    for (int i = 0; i < 5; i++) begin
      single_op(3'd3, 3'd0, 8'h81);
      single_op(v_mode[i], v_sh[i], 8'h00);
      chk($sformatf("barrel_%0d", i), pout_o, v_exp[i]);
    end

    // Burst of 5 rotate-left-by-1 from 8'h01, en toggling throughout.
    single_op(3'd3, 3'd0, 8'h01);
    start_i = 1'b1; mode_i = 3'd5; shamt_i = 3'd1; count_i = 8'd5;
    tick();
    start_i = 1'b0; mode_i = 3'd3; shamt_i = 3'd0; count_i = 8'd0; pin_i = 8'hFF;
    chk("burst_start_pout", pout_o, 8'h01);
    chk("burst_start_busy", busy_o, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      en_i = k[0];
      tick();
      chk($sformatf("burst_pout_%0d", k), pout_o, 8'h01 << k);
      chk($sformatf("burst_busy_%0d", k), busy_o, (k < 5) ? 1'b1 : 1'b0);
      chk($sformatf("burst_done_%0d", k), done_o, (k == 5) ? 1'b1 : 1'b0);
    end
    en_i = 1'b0;
    tick();
    chk("burst_done_drop", done_o, 1'b0);
    chk("burst_hold", pout_o, 8'h20);

    // Zero-count start completes immediately.
    start_i = 1'b1; mode_i = 3'd3; count_i = 8'd0;
    tick();
    start_i = 1'b0;
    chk("zero_pout", pout_o, 8'h20);
    chk("zero_busy", busy_o, 1'b0);
    chk("zero_done", done_o, 1'b1);
    tick();
    chk("zero_done_drop", done_o, 1'b0);

    // Burst of 10 shift-left with srin=1, aborted on the 4th RUN cycle.
    single_op(3'd3, 3'd0, 8'h00);
    srin_i = 1'b1;
    start_i = 1'b1; mode_i = 3'd2; count_i = 8'd10;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    chk("abort_pre", pout_o, 8'h07);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_pout", pout_o, 8'h07);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_done", done_o, 1'b0);
    tick();
    chk("abort_done_late", done_o, 1'b0);
    chk("abort_hold", pout_o, 8'h07);

    // abort in IDLE has no effect on a single op.
    abort_i = 1'b1;
    single_op(3'd3, 3'd0, 8'h3C);
    abort_i = 1'b0;
    chk("idle_abort_load", pout_o, 8'h3C);

    // Asynchronous reset mid-burst, then a normal burst.
    start_i = 1'b1; mode_i = 3'd2; count_i = 8'd10;
    tick();
    start_i = 1'b0;
    tick();
    chk("prerst_busy", busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pout", pout_o, 8'h00);
    chk("async_rst_busy", busy_o, 1'b0);
    tick();
    chk("rst_hold_done", done_o, 1'b0);
    #2 rst_n = 1'b1;
    srin_i = 1'b0;
    start_i = 1'b1; mode_i = 3'd3; count_i = 8'd2; pin_i = 8'h5A;
    tick();
    start_i = 1'b0;
    chk("post_rst_busy", busy_o, 1'b1);
    chk("post_rst_pout0", pout_o, 8'h00);
    tick();
    chk("post_rst_pout1", pout_o, 8'h5A);
    pin_i = 8'hC3;
    tick();
    chk("post_rst_live_pin", pout_o, 8'hC3);
    chk("post_rst_done", done_o, 1'b1);
    chk("post_rst_busy_end", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
